// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: program counter sequencer for a combinational-read instruction
// memory, presenting registered instructions to decode over a valid/ready handshake.
module inst_fetch_ctrl #(
   parameter int          MEM_DEPTH = 101,
   parameter int          PC_W      = 7,
   parameter int          RESET_PC  = 0,
   parameter logic [15:0] HALT_WORD = 16'h0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [31:0]     mem_addr,
   input  logic [15:0]     mem_data,
   output logic [15:0]     o_instr,
   output logic [PC_W-1:0] o_pc,
   output logic            o_valid,
   input  logic            o_ready,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_target,
   output logic            o_halted,
   output logic            o_err,
   output logic [15:0]     fetch_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   localparam logic [PC_W-1:0] PC0     = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(MEM_DEPTH - 1);
   state_t state, state_n;
   logic [PC_W-1:0] pc, pc_n, opc_n, pc_inc;
   logic [15:0] instr_n, cnt_n;
   logic valid_n, err_n, load, accept, branch, br_ok;
   assign mem_addr = 32'(pc);
   assign o_halted = state == HALT;
   assign accept   = o_valid && o_ready;
   assign branch   = br_valid && state != IDLE;
   assign br_ok    = 32'(br_target) < 32'(MEM_DEPTH);
   assign load     = state == RUN && !br_valid && (!o_valid || o_ready);
   assign pc_inc   = pc == PC_LAST ? '0 : pc + 1'b1;
   assign cnt_n    = fetch_cnt + {15'b0, accept && fetch_cnt != 16'hFFFF};
   // Branch outranks load and start; an unaccepted instruction otherwise holds.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = o_instr;
      opc_n   = o_pc;
      valid_n = o_valid && !o_ready;
      err_n   = o_err;
      if (branch) begin
         valid_n = 1'b0;
         if (br_ok) begin
            pc_n    = br_target;
            state_n = RUN;
         end else begin
            err_n   = 1'b1;
            state_n = HALT;
         end
      end else if (load) begin
         instr_n = mem_data;
         opc_n   = pc;
         valid_n = 1'b1;
         if (mem_data == HALT_WORD) state_n = HALT;
         else pc_n = pc_inc;
      end else if (start && state != RUN) begin
         state_n = RUN;
         pc_n    = PC0;
         valid_n = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= PC0;
         o_instr   <= 16'h0000;
         o_pc      <= '0;
         o_valid   <= 1'b0;
         o_err     <= 1'b0;
         fetch_cnt <= 16'h0000;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         o_instr   <= instr_n;
         o_pc      <= opc_n;
         o_valid   <= valid_n;
         o_err     <= err_n;
         fetch_cnt <= cnt_n;
      end
   end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed bench with an expected-instruction scoreboard
// for the fetch sequencer, plus a small-memory instance for PC wrap-around.
module tb_inst_fetch_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic start, o_ready, br_valid, o_valid, o_halted, o_err;
   logic [6:0] br_target, o_pc;
   logic [31:0] mem_addr;
   logic [15:0] mem_data, o_instr, fetch_cnt;
   logic start2, valid2, halted2, err2;
   logic [2:0] pc2;
   logic [31:0] addr2;
   logic [15:0] data2, instr2, cnt2;
   logic [15:0] mem [0:127];
   int total = 0, bad = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   assign mem_data = mem[mem_addr[6:0]];
   assign data2    = {13'h0200, addr2[2:0]};

   inst_fetch_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
      .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid), .o_ready(o_ready),
      .br_valid(br_valid), .br_target(br_target), .o_halted(o_halted),
      .o_err(o_err), .fetch_cnt(fetch_cnt)
   );

   inst_fetch_ctrl #(.MEM_DEPTH(8), .PC_W(3)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mem_addr(addr2), .mem_data(data2),
      .o_instr(instr2), .o_pc(pc2), .o_valid(valid2), .o_ready(1'b1),
      .br_valid(1'b0), .br_target(3'd0), .o_halted(halted2),
      .o_err(err2), .fetch_cnt(cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [6:0] pc);
      exp_q.push_back({9'b0, pc, mem[pc]});
   endtask

   task automatic push_prog();
      for (int i = 0; i < 7; i++) push(7'(i));
   endtask

   // Every accepted instruction must be the next one the stimulus expects.
   always @(negedge clk) begin
      if (!rst && o_valid && o_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_unexpected observed=%h expected=none", {9'b0, o_pc, o_instr});
         end else chk("sb_accept", {9'b0, o_pc, o_instr}, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'h1234;
      mem[0] = 16'hffff; mem[1] = 16'hb105; mem[2] = 16'hb104; mem[3] = 16'hb10f;
      mem[4] = 16'hb102; mem[5] = 16'h0211; mem[6] = 16'h0000;
      start = 0; start2 = 0; o_ready = 0; br_valid = 0; br_target = '0;
      #1;
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_cnt", 32'(fetch_cnt), 0);
      chk("rst_halted", 32'(o_halted), 0);
      chk("rst_err", 32'(o_err), 0);
      chk("rst_instr", 32'(o_instr), 0);
      cyc(); rst = 0; cyc();
      chk("idle_valid", 32'(o_valid), 0);
      // wrap-around on the 8-word instance
      start2 = 1; cyc(); start2 = 0;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         if (k >= 7) begin
            chk("wrap_pc", 32'(pc2), 32'((k - 1) % 8));
            chk("wrap_valid", 32'(valid2), 1);
         end
      end
      // sequential run
      push_prog(); o_ready = 1; start = 1; cyc(); start = 0;
      chk("start_addr", mem_addr, 0);
      chk("start_valid", 32'(o_valid), 0);
      cyc();
      chk("first_instr", 32'(o_instr), 32'hffff);
      repeat (6) cyc();
      chk("halt_instr", 32'(o_instr), 0);
      chk("halt_pc", 32'(o_pc), 6);
      chk("halt_flag", 32'(o_halted), 1);
      cyc();
      chk("seq_cnt", 32'(fetch_cnt), 7);
      chk("seq_drained", 32'(o_valid), 0);
      chk("halt_addr", mem_addr, 6);
      chk("seq_q", 32'(exp_q.size()), 0);
      // backpressure
      push_prog(); start = 1; cyc(); start = 0;
      chk("restart_halted", 32'(o_halted), 0);
      repeat (3) cyc();
      chk("bp_instr0", 32'(o_instr), 32'hb104);
      o_ready = 0;
      repeat (3) begin
         cyc();
         chk("bp_instr", 32'(o_instr), 32'hb104);
         chk("bp_pc", 32'(o_pc), 2);
         chk("bp_addr", mem_addr, 3);
      end
      o_ready = 1; cyc();
      chk("bp_next", {9'b0, o_pc, o_instr}, {9'b0, 7'd3, 16'hb10f});
      repeat (4) cyc();
      chk("bp_cnt", 32'(fetch_cnt), 14);
      chk("bp_q", 32'(exp_q.size()), 0);
      // branch flush
      for (int i = 0; i < 4; i++) push(7'(i));
      for (int i = 1; i < 7; i++) push(7'(i));
      start = 1; cyc(); start = 0;
      repeat (5) cyc();
      chk("br_pre", {9'b0, o_pc, o_instr}, {9'b0, 7'd4, 16'hb102});
      o_ready = 0; br_valid = 1; br_target = 7'd1; cyc(); br_valid = 0; o_ready = 1;
      chk("br_flush", 32'(o_valid), 0);
      chk("br_addr", mem_addr, 1);
      cyc();
      chk("br_target_word", {9'b0, o_pc, o_instr}, {9'b0, 7'd1, 16'hb105});
      repeat (5) cyc();
      chk("br_halted", 32'(o_halted), 1);
      cyc();
      chk("br_cnt", 32'(fetch_cnt), 24);
      chk("br_q", 32'(exp_q.size()), 0);
      // out-of-range branch target
      start = 1; cyc(); start = 0; o_ready = 0;
      cyc();
      chk("bad_pre", 32'(o_valid), 1);
      br_valid = 1; br_target = 7'd120; cyc(); br_valid = 0;
      chk("bad_err", 32'(o_err), 1);
      chk("bad_halted", 32'(o_halted), 1);
      chk("bad_valid", 32'(o_valid), 0);
      chk("bad_addr", mem_addr, 1);
      chk("bad_cnt", 32'(fetch_cnt), 24);
      cyc();
      chk("halt_nofetch", mem_addr, 1);
      push_prog(); o_ready = 1; start = 1; cyc(); start = 0;
      chk("resume_addr", mem_addr, 0);
      chk("resume_err", 32'(o_err), 1);
      chk("resume_halted", 32'(o_halted), 0);
      repeat (8) cyc();
      chk("resume_cnt", 32'(fetch_cnt), 31);
      chk("resume_q", 32'(exp_q.size()), 0);
      // asynchronous reset mid-run
      push(7'd0); push(7'd1);
      start = 1; cyc(); start = 0;
      repeat (3) cyc();
      chk("ar_pre", 32'(o_valid), 1);
      #1 rst = 1;
      #1;
      chk("ar_valid", 32'(o_valid), 0);
      chk("ar_addr", mem_addr, 0);
      chk("ar_cnt", 32'(fetch_cnt), 0);
      chk("ar_err", 32'(o_err), 0);
      chk("ar_halted", 32'(o_halted), 0);
      chk("ar_q", 32'(exp_q.size()), 0);
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Instruction fetch sequencer for the filter processor.
- Owns the program counter and drives the 32-bit address into the combinational-read instruction memory.
- Registers the returned 16-bit instruction toward decode through a valid/ready handshake.
- Handles start, branch redirect with flush, halt detection and out-of-range target errors.

Parameters:
- MEM_DEPTH, 101: number of instruction words; valid PC range is 0..MEM_DEPTH-1.
- PC_W, 7: PC register width; must satisfy 2^PC_W >= MEM_DEPTH.
- RESET_PC, 0: PC loaded at reset and on every start.
- HALT_WORD, 16'h0000: instruction encoding that stops fetching.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins execution from RESET_PC.
- mem_addr  out  32  address to instruction memory; equals PC zero-extended.
- mem_data  in  16  instruction word, valid in the same cycle as mem_addr (combinational read).
- o_instr  out  16  registered instruction for decode.
- o_pc  out  PC_W  address that o_instr was fetched from.
- o_valid  out  1  o_instr/o_pc are valid.
- o_ready  in  1  decode accepts o_instr this cycle.
- br_valid  in  1  branch redirect request.
- br_target  in  PC_W  branch destination.
- o_halted  out  1  high while in HALT.
- o_err  out  1  sticky flag: an out-of-range branch target was seen.
- fetch_cnt  out  16  count of accepted instructions (o_valid && o_ready); saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, pc=RESET_PC, o_valid=0, o_instr=16'h0000, o_pc=0, o_halted=0, o_err=0, fetch_cnt=0.
  - Reset asserted mid-run discards any pending instruction.
- mem_addr = {zeros, pc} at all times.
- Load condition: load = (state==RUN) && !br_valid && (!o_valid || o_ready).
- IDLE:
  - o_valid=0.
  - br_valid is ignored.
  - start -> RUN, pc=RESET_PC.
- RUN, on load:
  - o_instr<=mem_data, o_pc<=pc, o_valid<=1.
  - If mem_data != HALT_WORD: pc<=pc+1, wrapping MEM_DEPTH-1 -> 0.
  - If mem_data == HALT_WORD: pc holds and state<=HALT. The halt word itself is still presented to decode.
- RUN, stall (o_valid && !o_ready): o_instr, o_pc, o_valid and pc all hold.
  - 16'hffff is an ordinary instruction (NOP filler) and does not stall.
- Latency: an instruction appears on o_instr one cycle after its address is on mem_addr. Sustained throughput is 1 instruction/cycle while o_ready=1.
- Accept without load: when o_valid && o_ready and no new load occurs, o_valid<=0 next cycle.
- Branch (br_valid in RUN or HALT); branch wins over load and over start:
  - Always: o_valid<=0 (flush; the in-flight instruction is dropped and not counted).
  - br_target < MEM_DEPTH: pc<=br_target, state<=RUN. The first target instruction appears 2 cycles after the br_valid edge.
  - br_target >= MEM_DEPTH: o_err<=1 (sticky until reset), state<=HALT, pc unchanged.
- HALT:
  - o_halted=1; no fetches occur.
  - A pending o_valid clears when accepted.
  - start -> RUN with pc=RESET_PC, o_valid<=0. o_err is not cleared.
- start while in RUN is ignored.
- fetch_cnt increments on every o_valid && o_ready cycle, including the halt word. It holds at 16'hFFFF.

Test Plan:
- Sequential run: memory 0:ffff, 1:b105, 2:b104, 3:b10f, 4:b102, 5:0211, 6:0000; reset, start, o_ready=1 -> o_instr sequence ffff, b105, b104, b10f, b102, 0211, 0000 on consecutive cycles with o_pc 0..6; o_halted=1 after the 0000 word; fetch_cnt=7.
- Backpressure: same program, o_ready=0 for 3 cycles while o_instr=b104 -> o_instr, o_pc=2 and mem_addr=3 hold; releasing o_ready gives b10f next cycle with no duplicate or skipped word.
- Branch flush: br_valid with br_target=1 in the cycle o_pc=4 is valid and unaccepted -> o_valid=0 next cycle, then o_instr=b105 with o_pc=1; b102 is never counted.
- Bad target: MEM_DEPTH=101, br_target=120 -> o_err=1, o_halted=1, o_valid=0; a later start resumes from pc 0 with o_err still 1.
- Wrap-around: MEM_DEPTH=8, no halt word in memory -> o_pc sequence 6, 7, 0, 1.
- Async reset mid-run: assert rst between clock edges while o_valid=1 -> o_valid=0, mem_addr=0, fetch_cnt=0 immediately, without waiting for a clock edge.
